// File: rtl/sap_u_pkg.sv
// Shared definitions for the SAP-style control sequencer: opcodes, microsteps
// and control-word bit positions.
package sap_u_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_LDA = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_STA = 4'b0100,
        OP_LDI = 4'b0101,
        OP_JMP = 4'b0110,
        OP_JC  = 4'b0111,
        OP_JZ  = 4'b1000,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_t;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    // Internal control word is active-high; the top inverts the *_n outputs.
    localparam int unsigned CW_WIDTH    = 14;
    localparam int unsigned CW_A_LOAD   = 0;
    localparam int unsigned CW_A_BUS    = 1;
    localparam int unsigned CW_B_LOAD   = 2;
    localparam int unsigned CW_ALU_EN   = 3;
    localparam int unsigned CW_RAM_BUS  = 4;
    localparam int unsigned CW_RAM_WE   = 5;
    localparam int unsigned CW_MAR_LOAD = 6;
    localparam int unsigned CW_IR_LOAD  = 7;
    localparam int unsigned CW_IR_BUS   = 8;
    localparam int unsigned CW_JUMP     = 9;
    localparam int unsigned CW_PC_BUS   = 10;
    localparam int unsigned CW_OUT_LOAD = 11;
    localparam int unsigned CW_ALU_SUB  = 12;
    localparam int unsigned CW_PC_EN    = 13;

endpackage

// File: rtl/step_counter.sv
// Microstep counter T0..T4 with async clear, enable, synchronous restart to T0
// and freeze (freeze overrides restart and advance).
module step_counter
    import sap_u_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  enable,
    input  logic  restart,
    input  logic  freeze,
    output step_t step
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step <= T0;
        end else if (enable && !freeze) begin
            if (restart) begin
                step <= T0;
            end else begin
                step <= step_t'(step + 3'd1);
            end
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: decodes control lines from step, opcode and
// flags. Define CONDITIONAL_JUMP_EN to build the flags register and JC/JZ.
module control_sequencer
    import sap_u_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       step_enable,
    input  logic [3:0] opcode,
    input  logic       carry_in,
    input  logic       zero_in,
    output logic       reg_a_load_n,
    output logic       reg_a_bus_enable_n,
    output logic       reg_b_load_n,
    output logic       alu_enable_n,
    output logic       ram_bus_enable_n,
    output logic       ram_write_enable_n,
    output logic       ram_load_mar_reg_n,
    output logic       ir_load_n,
    output logic       ir_bus_enable_n,
    output logic       jump_n,
    output logic       program_counter_bus_enable_n,
    output logic       out_load_n,
    output logic       alu_subtract,
    output logic       program_counter_enable,
    output logic       halted,
    output logic [2:0] step
);

    step_t                cur_step;
    opcode_t              op;
    logic [CW_WIDTH-1:0]  cw;
    logic [CW_WIDTH-1:0]  cw_out;
    logic                 last_step;
    logic                 halt_req;
    logic                 flags_load;
    logic                 halted_q;

    assign op = opcode_t'(opcode);

    step_counter u_step_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (step_enable),
        .restart (last_step),
        .freeze  (halted_q | halt_req),
        .step    (cur_step)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            halted_q <= 1'b0;
        end else if (step_enable && halt_req) begin
            halted_q <= 1'b1;
        end
    end

`ifdef CONDITIONAL_JUMP_EN
    logic carry_flag;
    logic zero_flag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
        end else if (step_enable && !halted_q && flags_load) begin
            carry_flag <= carry_in;
            zero_flag  <= zero_in;
        end
    end
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = carry_in ^ zero_in ^ flags_load;
`endif

    always_comb begin
        cw         = '0;
        last_step  = 1'b0;
        halt_req   = 1'b0;
        flags_load = 1'b0;
        case (cur_step)
            T0: begin
                cw[CW_PC_BUS]   = 1'b1;
                cw[CW_MAR_LOAD] = 1'b1;
            end
            T1: begin
                cw[CW_RAM_BUS] = 1'b1;
                cw[CW_IR_LOAD] = 1'b1;
                cw[CW_PC_EN]   = 1'b1;
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
                    OP_JMP, OP_OUT, OP_HLT: last_step = 1'b0;
`ifdef CONDITIONAL_JUMP_EN
                    OP_JC, OP_JZ:           last_step = 1'b0;
`endif
                    default:                last_step = 1'b1;
                endcase
            end
            T2: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw[CW_IR_BUS]   = 1'b1;
                        cw[CW_MAR_LOAD] = 1'b1;
                    end
                    OP_LDI: begin
                        cw[CW_IR_BUS] = 1'b1;
                        cw[CW_A_LOAD] = 1'b1;
                        last_step     = 1'b1;
                    end
                    OP_JMP: begin
                        cw[CW_IR_BUS] = 1'b1;
                        cw[CW_JUMP]   = 1'b1;
                        last_step     = 1'b1;
                    end
`ifdef CONDITIONAL_JUMP_EN
                    OP_JC: begin
                        cw[CW_IR_BUS] = carry_flag;
                        cw[CW_JUMP]   = carry_flag;
                        last_step     = 1'b1;
                    end
                    OP_JZ: begin
                        cw[CW_IR_BUS] = zero_flag;
                        cw[CW_JUMP]   = zero_flag;
                        last_step     = 1'b1;
                    end
`endif
                    OP_OUT: begin
                        cw[CW_A_BUS]   = 1'b1;
                        cw[CW_OUT_LOAD] = 1'b1;
                        last_step      = 1'b1;
                    end
                    OP_HLT:  halt_req  = 1'b1;
                    default: last_step = 1'b1;
                endcase
            end
            T3: begin
                case (op)
                    OP_LDA: begin
                        cw[CW_RAM_BUS] = 1'b1;
                        cw[CW_A_LOAD]  = 1'b1;
                        last_step      = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_RAM_BUS] = 1'b1;
                        cw[CW_B_LOAD]  = 1'b1;
                    end
                    OP_STA: begin
                        cw[CW_A_BUS]  = 1'b1;
                        cw[CW_RAM_WE] = 1'b1;
                        last_step     = 1'b1;
                    end
                    default: last_step = 1'b1;
                endcase
            end
            T4: begin
                if (op == OP_ADD || op == OP_SUB) begin
                    cw[CW_ALU_EN]  = 1'b1;
                    cw[CW_A_LOAD]  = 1'b1;
                    cw[CW_ALU_SUB] = (op == OP_SUB);
                    flags_load     = 1'b1;
                end
                last_step = 1'b1;
            end
            default: last_step = 1'b1;
        endcase
    end

    // Reset and halt mask every control line, including the T0 fetch decode.
    assign cw_out = (reset_n && !halted_q) ? cw : '0;

    assign reg_a_load_n                 = ~cw_out[CW_A_LOAD];
    assign reg_a_bus_enable_n           = ~cw_out[CW_A_BUS];
    assign reg_b_load_n                 = ~cw_out[CW_B_LOAD];
    assign alu_enable_n                 = ~cw_out[CW_ALU_EN];
    assign ram_bus_enable_n             = ~cw_out[CW_RAM_BUS];
    assign ram_write_enable_n           = ~cw_out[CW_RAM_WE];
    assign ram_load_mar_reg_n           = ~cw_out[CW_MAR_LOAD];
    assign ir_load_n                    = ~cw_out[CW_IR_LOAD];
    assign ir_bus_enable_n              = ~cw_out[CW_IR_BUS];
    assign jump_n                       = ~cw_out[CW_JUMP];
    assign program_counter_bus_enable_n = ~cw_out[CW_PC_BUS];
    assign out_load_n                   = ~cw_out[CW_OUT_LOAD];
    assign alu_subtract                 = cw_out[CW_ALU_SUB];
    assign program_counter_enable       = cw_out[CW_PC_EN];
    assign halted                       = halted_q;
    assign step                         = cur_step;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer; expectations follow the build's
// CONDITIONAL_JUMP_EN setting.
module tb_control_sequencer;

    localparam logic [11:0] A_LD    = 12'h800;
    localparam logic [11:0] A_BUS   = 12'h400;
    localparam logic [11:0] B_LD    = 12'h200;
    localparam logic [11:0] ALU     = 12'h100;
    localparam logic [11:0] RAM_BUS = 12'h080;
    localparam logic [11:0] RAM_WE  = 12'h040;
    localparam logic [11:0] MAR     = 12'h020;
    localparam logic [11:0] IR_LD   = 12'h010;
    localparam logic [11:0] IR_BUS  = 12'h008;
    localparam logic [11:0] JMP     = 12'h004;
    localparam logic [11:0] PC_BUS  = 12'h002;
    localparam logic [11:0] OUT     = 12'h001;
    localparam logic [11:0] NONE    = 12'h000;
    localparam logic [11:0] F0      = PC_BUS | MAR;
    localparam logic [11:0] F1      = RAM_BUS | IR_LD;
    localparam logic [2:0]  H_SUB   = 3'b100;
    localparam logic [2:0]  H_PCEN  = 3'b010;
    localparam logic [2:0]  H_HALT  = 3'b001;

    logic clk = 1'b0;
    logic reset_n, step_enable, carry_in, zero_in;
    logic [3:0] opcode;
    logic reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n, alu_enable_n;
    logic ram_bus_enable_n, ram_write_enable_n, ram_load_mar_reg_n, ir_load_n;
    logic ir_bus_enable_n, jump_n, program_counter_bus_enable_n, out_load_n;
    logic alu_subtract, program_counter_enable, halted;
    logic [2:0] step;

    control_sequencer dut (
        .clk                          (clk),
        .reset_n                      (reset_n),
        .step_enable                  (step_enable),
        .opcode                       (opcode),
        .carry_in                     (carry_in),
        .zero_in                      (zero_in),
        .reg_a_load_n                 (reg_a_load_n),
        .reg_a_bus_enable_n           (reg_a_bus_enable_n),
        .reg_b_load_n                 (reg_b_load_n),
        .alu_enable_n                 (alu_enable_n),
        .ram_bus_enable_n             (ram_bus_enable_n),
        .ram_write_enable_n           (ram_write_enable_n),
        .ram_load_mar_reg_n           (ram_load_mar_reg_n),
        .ir_load_n                    (ir_load_n),
        .ir_bus_enable_n              (ir_bus_enable_n),
        .jump_n                       (jump_n),
        .program_counter_bus_enable_n (program_counter_bus_enable_n),
        .out_load_n                   (out_load_n),
        .alu_subtract                 (alu_subtract),
        .program_counter_enable       (program_counter_enable),
        .halted                       (halted),
        .step                         (step)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] step;
        logic [11:0] low_n;
        logic [2:0] high;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [11:0] act_low_n();
        return {reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n, alu_enable_n,
                ram_bus_enable_n, ram_write_enable_n, ram_load_mar_reg_n, ir_load_n,
                ir_bus_enable_n, jump_n, program_counter_bus_enable_n, out_load_n};
    endfunction

    // Monitor: drains the expectation queue whenever stimulus posts a sample point.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (step !== e.step || act_low_n() !== e.low_n ||
                    {alu_subtract, program_counter_enable, halted} !== e.high) begin
                    n_fail++;
                    $display("FAIL %s: got step=%0d low_n=%b high=%b, expected step=%0d low_n=%b high=%b",
                             e.name, step, act_low_n(),
                             {alu_subtract, program_counter_enable, halted},
                             e.step, e.low_n, e.high);
                end
            end
        end
    end

    // Bus drivers must be one-hot-or-none at every sample point.
    always @(negedge clk) begin
        n_checks++;
        if ($countones(~{reg_a_bus_enable_n, alu_enable_n, ram_bus_enable_n,
                         ir_bus_enable_n, program_counter_bus_enable_n}) > 1) begin
            n_fail++;
            $display("FAIL bus_onehot: step=%0d opcode=%b low_n=%b, required at most one bus driver",
                     step, opcode, act_low_n());
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int st, input logic [11:0] act, input logic [2:0] hi);
        exp_t e;
        e.name  = nm;
        e.step  = 3'(st);
        e.low_n = ~act;
        e.high  = hi;
        exp_q.push_back(e);
        ->chk_ev;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        reset_n     = 1'b1;
        step_enable = 1'b1;
        opcode      = 4'b0000;
        carry_in    = 1'b0;
        zero_in     = 1'b0;
        #1 reset_n  = 1'b0;
        #11;
        chk("reset_state", 0, NONE, 3'b000);
        @(negedge clk);
        reset_n = 1'b1;

        // NOP: two-step instructions back to back
        chk("nop_t0", 0, F0, 3'b000);         tick;
        chk("nop_t1", 1, F1, H_PCEN);         tick;
        chk("nop_t0b", 0, F0, 3'b000);        tick;
        chk("nop_t1b", 1, F1, H_PCEN);        tick;

        opcode = 4'b0001;                     tick; tick;
        chk("lda_t2", 2, IR_BUS | MAR, 3'b000); tick;
        chk("lda_t3", 3, RAM_BUS | A_LD, 3'b000); tick;
        chk("lda_end", 0, F0, 3'b000);

        opcode = 4'b0101;                     tick; tick;
        chk("ldi_t2", 2, IR_BUS | A_LD, 3'b000); tick;
        chk("ldi_end", 0, F0, 3'b000);

        opcode = 4'b0110;                     tick; tick;
        chk("jmp_t2", 2, IR_BUS | JMP, 3'b000); tick;
        chk("jmp_end", 0, F0, 3'b000);

        opcode = 4'b1110;                     tick; tick;
        chk("out_t2", 2, A_BUS | OUT, 3'b000); tick;
        chk("out_end", 0, F0, 3'b000);

        opcode = 4'b1010;                     tick;
        chk("undef_t1", 1, F1, H_PCEN);       tick;
        chk("undef_end", 0, F0, 3'b000);

        opcode = 4'b0011; carry_in = 1'b0; zero_in = 1'b1;
        tick; tick; tick;
        chk("sub_t3", 3, RAM_BUS | B_LD, 3'b000); tick;
        chk("sub_t4", 4, ALU | A_LD, H_SUB);  tick;
        chk("sub_end", 0, F0, 3'b000);

        opcode = 4'b0010; carry_in = 1'b1; zero_in = 1'b0;
        tick; tick;
        chk("add_t2", 2, IR_BUS | MAR, 3'b000); tick;
        chk("add_t3", 3, RAM_BUS | B_LD, 3'b000); tick;
        chk("add_t4", 4, ALU | A_LD, 3'b000); tick;
        chk("add_end", 0, F0, 3'b000);
        carry_in = 1'b0; zero_in = 1'b1;

`ifdef CONDITIONAL_JUMP_EN
        opcode = 4'b0111;                     tick; tick;
        chk("jc_taken_t2", 2, IR_BUS | JMP, 3'b000); tick;
        chk("jc_end", 0, F0, 3'b000);
        opcode = 4'b1000;                     tick; tick;
        chk("jz_not_taken_t2", 2, NONE, 3'b000); tick;
        chk("jz_end", 0, F0, 3'b000);
`else
        opcode = 4'b0111;                     tick;
        chk("jc_nop_t1", 1, F1, H_PCEN);      tick;
        chk("jc_end", 0, F0, 3'b000);
        opcode = 4'b1000;                     tick;
        chk("jz_nop_t1", 1, F1, H_PCEN);      tick;
        chk("jz_end", 0, F0, 3'b000);
`endif

        opcode = 4'b0100;                     tick; tick;
        chk("sta_t2", 2, IR_BUS | MAR, 3'b000); tick;
        chk("sta_t3", 3, A_BUS | RAM_WE, 3'b000);
        step_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("sta_hold", 3, A_BUS | RAM_WE, 3'b000);
        end
        step_enable = 1'b1;                   tick;
        chk("sta_resume", 0, F0, 3'b000);

        // Async reset during ADD T3
        opcode = 4'b0010;                     tick; tick; tick;
        chk("ar_t3", 3, RAM_BUS | B_LD, 3'b000);
        #1 reset_n = 1'b0;
        #1 chk("ar_reset_now", 0, NONE, 3'b000);
        @(negedge clk);
        reset_n = 1'b1;
        chk("ar_release_t0", 0, F0, 3'b000);  tick;
        chk("ar_first_edge_t1", 1, F1, H_PCEN);
        repeat (4) tick;

        opcode = 4'b1111;                     tick; tick;
        chk("hlt_t2", 2, NONE, 3'b000);       tick;
        chk("hlt_set", 2, NONE, H_HALT);
        opcode = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            step_enable = i[0];
            tick;
            chk("hlt_frozen", 2, NONE, H_HALT);
        end
        step_enable = 1'b1;
        reset_n = 1'b0;
        #1 chk("hlt_reset", 0, NONE, 3'b000);
        reset_n = 1'b1;
        #1 chk("hlt_release", 0, F0, 3'b000);

        // Every opcode through every step for the bus one-hot check
        for (int op = 0; op < 16; op++) begin
            @(negedge clk);
            reset_n = 1'b0;
            #2 reset_n = 1'b1;
            opcode = 4'(op);
            repeat (6) tick;
        end

        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
